// File: rtl/pmem_arbiter_burst.sv
// ----------------------------------------------------------------------------
// pmem_arbiter_burst
//
// Purpose:
//   Shares one burst memory port between the I-cache (line reads only) and the
//   D-cache (line reads and writebacks). A granted LINE_W request is carried out
//   as BEATS consecutive BURST_W beats on the memory side. The assembled line
//   is returned with a single-cycle resp pulse, matching the cache pmem
//   handshake.
//
// Optional feature:
//   PMEM_ARB_ROUND_ROBIN_EN - when defined, simultaneous requests are granted to
//   the client that was not granted last. When undefined, the D-cache always
//   wins over the I-cache.
//
// Ports:
//   clk, rst_n                  clock (rising edge), async active-low reset
//   i_pmem_read/address         I-cache line read request, held until resp
//   i_pmem_rdata/resp           last line read for the I-cache, done pulse
//   d_pmem_read/write/address   D-cache line request (write beats read)
//   d_pmem_wdata                D-cache writeback line
//   d_pmem_rdata/resp           last line read for the D-cache, done pulse
//   burst_read/write            memory burst direction, held for whole burst
//   burst_address               line-aligned burst address
//   burst_wdata                 current write beat
//   burst_rdata                 current read beat
//   burst_resp                  one beat transferred this cycle
// ----------------------------------------------------------------------------
module pmem_arbiter_burst #(
    parameter int LINE_W  = 256,
    parameter int BURST_W = 64,
    parameter int ADDR_W  = 32
) (
    input  logic                clk,
    input  logic                rst_n,

    input  logic                i_pmem_read,
    input  logic [ADDR_W-1:0]   i_pmem_address,
    output logic [LINE_W-1:0]   i_pmem_rdata,
    output logic                i_pmem_resp,

    input  logic                d_pmem_read,
    input  logic                d_pmem_write,
    input  logic [ADDR_W-1:0]   d_pmem_address,
    input  logic [LINE_W-1:0]   d_pmem_wdata,
    output logic [LINE_W-1:0]   d_pmem_rdata,
    output logic                d_pmem_resp,

    output logic                burst_read,
    output logic                burst_write,
    output logic [ADDR_W-1:0]   burst_address,
    output logic [BURST_W-1:0]  burst_wdata,
    input  logic [BURST_W-1:0]  burst_rdata,
    input  logic                burst_resp
);

    localparam int BEATS  = LINE_W / BURST_W;
    localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0]  LAST_BEAT   = CNT_W'(BEATS - 1);
    // Byte-offset bits inside one line; cleared to form the burst address.
    localparam logic [ADDR_W-1:0] OFFSET_MASK = ADDR_W'(LINE_W / 8 - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [CNT_W-1:0]    cnt_q;
    logic                gnt_d_q;      // 1: transaction belongs to the D-cache

    logic [ADDR_W-1:0]   addr_q;
    logic [LINE_W-1:0]   wline_q;
    logic [LINE_W-1:0]   rline_q;
    logic [LINE_W-1:0]   i_rdata_q;
    logic [LINE_W-1:0]   d_rdata_q;

    logic                req_i;
    logic                req_d;
    logic                any_req;
    logic                win_d;
    logic                win_wr;
    logic                grant_en;
    logic                in_burst;
    logic                beat_done;
    logic                last_beat;
    logic                rd_line_done;
    logic [ADDR_W-1:0]   sel_addr;
    logic [LINE_W-1:0]   line_asm;

    // ------------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------------
    assign req_i   = i_pmem_read;
    assign req_d   = d_pmem_read | d_pmem_write;
    assign any_req = req_i | req_d;

`ifdef PMEM_ARB_ROUND_ROBIN_EN
    // Remembers who won the previous grant so a tie goes to the other client.
    // Resets to the I-cache so the D-cache takes the first tie.
    logic last_d_q;

    assign win_d = req_d & (~req_i | ~last_d_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_d_q <= 1'b0;
        end else if (grant_en) begin
            last_d_q <= win_d;
        end
    end
`else
    assign win_d = req_d;
`endif

    // A D-cache request with both read and write high is served as a write.
    assign win_wr   = win_d & d_pmem_write;
    assign grant_en = (state_q == IDLE) && any_req;
    assign sel_addr = win_d ? d_pmem_address : i_pmem_address;

    // ------------------------------------------------------------------------
    // Beat bookkeeping
    // ------------------------------------------------------------------------
    assign in_burst     = (state_q == READ) || (state_q == WRITE);
    assign beat_done    = in_burst && burst_resp;
    assign last_beat    = (cnt_q == LAST_BEAT);
    assign rd_line_done = (state_q == READ) && burst_resp && last_beat;

    // Line buffer with the current beat merged in; on the final beat this is
    // the complete line, so the client register can load it directly.
    always_comb begin
        line_asm = rline_q;
        line_asm[int'(cnt_q) * BURST_W +: BURST_W] = burst_rdata;
    end

    // ------------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d = win_wr ? WRITE : READ;
                end
            end
            READ: begin
                if (burst_resp && last_beat) begin
                    state_d = DONE;
                end
            end
            WRITE: begin
                if (burst_resp && last_beat) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------------
    always_comb begin
        burst_read    = 1'b0;
        burst_write   = 1'b0;
        burst_address = '0;
        burst_wdata   = '0;
        i_pmem_resp   = 1'b0;
        d_pmem_resp   = 1'b0;
        case (state_q)
            READ: begin
                burst_read    = 1'b1;
                burst_address = addr_q;
            end
            WRITE: begin
                burst_write   = 1'b1;
                burst_address = addr_q;
                burst_wdata   = wline_q[int'(cnt_q) * BURST_W +: BURST_W];
            end
            DONE: begin
                i_pmem_resp   = ~gnt_d_q;
                d_pmem_resp   = gnt_d_q;
            end
            default: begin
            end
        endcase
    end

    assign i_pmem_rdata = i_rdata_q;
    assign d_pmem_rdata = d_rdata_q;

    // ------------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            gnt_d_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (grant_en) begin
                cnt_q   <= '0;
                gnt_d_q <= win_d;
            end else if (beat_done) begin
                cnt_q <= last_beat ? '0 : cnt_q + CNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Transaction data (only meaningful while a burst is owned)
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (grant_en) begin
            addr_q <= sel_addr & ~OFFSET_MASK;
            if (win_wr) begin
                wline_q <= d_pmem_wdata;
            end
        end
        if ((state_q == READ) && burst_resp) begin
            rline_q <= line_asm;
        end
    end

    // ------------------------------------------------------------------------
    // Per-client returned lines; they only change when that client's read
    // finishes, so a write or the other client's traffic leaves them intact.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else if (rd_line_done) begin
            if (gnt_d_q) begin
                d_rdata_q <= line_asm;
            end else begin
                i_rdata_q <= line_asm;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Invariants
    // ------------------------------------------------------------------------
    a_one_dir: assert property (@(posedge clk) disable iff (!rst_n)
        !(burst_read && burst_write));
    a_one_resp: assert property (@(posedge clk) disable iff (!rst_n)
        !(i_pmem_resp && d_pmem_resp));

endmodule

// File: tb/tb_pmem_arbiter_burst.sv
// ----------------------------------------------------------------------------
// Testbench for pmem_arbiter_burst: a table of single-client transactions plus
// hand-written sequences for contention, round-robin history and reset abort.
// A background memory model answers bursts using a per-transaction beat
// pattern and a line store keyed by aligned address.
// ----------------------------------------------------------------------------
module tb_pmem_arbiter_burst;

    localparam int LINE_W  = 256;
    localparam int BURST_W = 64;
    localparam int ADDR_W  = 32;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                i_pmem_read;
    logic [ADDR_W-1:0]   i_pmem_address;
    logic [LINE_W-1:0]   i_pmem_rdata;
    logic                i_pmem_resp;
    logic                d_pmem_read;
    logic                d_pmem_write;
    logic [ADDR_W-1:0]   d_pmem_address;
    logic [LINE_W-1:0]   d_pmem_wdata;
    logic [LINE_W-1:0]   d_pmem_rdata;
    logic                d_pmem_resp;
    logic                burst_read;
    logic                burst_write;
    logic [ADDR_W-1:0]   burst_address;
    logic [BURST_W-1:0]  burst_wdata;
    logic [BURST_W-1:0]  burst_rdata;
    logic                burst_resp;

    pmem_arbiter_burst #(.LINE_W(LINE_W), .BURST_W(BURST_W), .ADDR_W(ADDR_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_pmem_read    (i_pmem_read),
        .i_pmem_address (i_pmem_address),
        .i_pmem_rdata   (i_pmem_rdata),
        .i_pmem_resp    (i_pmem_resp),
        .d_pmem_read    (d_pmem_read),
        .d_pmem_write   (d_pmem_write),
        .d_pmem_address (d_pmem_address),
        .d_pmem_wdata   (d_pmem_wdata),
        .d_pmem_rdata   (d_pmem_rdata),
        .d_pmem_resp    (d_pmem_resp),
        .burst_read     (burst_read),
        .burst_write    (burst_write),
        .burst_address  (burst_address),
        .burst_wdata    (burst_wdata),
        .burst_rdata    (burst_rdata),
        .burst_resp     (burst_resp)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit           is_d;
        bit           rd;
        bit           wr;
        logic [31:0]  addr;
        logic [255:0] line;
        logic [15:0]  pat;
        logic [31:0]  exp_addr;
        bit           exp_wr;
        int           exp_lat;
    } vec_t;

    vec_t vecs[5];

    // Memory model state
    logic [255:0] mem [logic [31:0]];
    logic [15:0]  resp_pat;
    logic [255:0] cur_wline;
    logic [255:0] wr_got;
    logic [31:0]  got_addr;
    bit           saw_read, saw_write, hold_err;
    bit           rw_err, both_resp_err, done_burst_err;
    int           i_cnt, d_cnt;
    bit           order_q[$];     // 1 = D-cache resp, 0 = I-cache resp
    int           pidx, rb;

    // Bench bookkeeping
    int           pass_cnt, chk_cnt;
    logic [255:0] i_exp, d_exp;
    logic [255:0] i_at_resp, d_at_resp;

    task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    function automatic vec_t mk(input bit is_d, input bit rd, input bit wr,
                                input logic [31:0] addr, input logic [255:0] line,
                                input logic [15:0] pat, input logic [31:0] exp_addr,
                                input bit exp_wr, input int exp_lat);
        vec_t v;
        v.is_d = is_d; v.rd = rd; v.wr = wr; v.addr = addr; v.line = line;
        v.pat = pat; v.exp_addr = exp_addr; v.exp_wr = exp_wr; v.exp_lat = exp_lat;
        return v;
    endfunction

    // Memory responder and resp monitor, evaluated on the falling edge.
    initial begin
        logic [255:0] ml;
        burst_resp  = 1'b0;
        burst_rdata = '0;
        pidx = 0;
        rb   = 0;
        forever begin
            @(negedge clk);
            if (burst_read && burst_write) rw_err = 1'b1;
            if (i_pmem_resp && d_pmem_resp) both_resp_err = 1'b1;
            if ((i_pmem_resp || d_pmem_resp) && (burst_read || burst_write)) done_burst_err = 1'b1;
            if (i_pmem_resp) begin i_cnt++; order_q.push_back(1'b0); end
            if (d_pmem_resp) begin d_cnt++; order_q.push_back(1'b1); end
            if (burst_read || burst_write) begin
                if (pidx == 0) begin
                    got_addr = burst_address;
                    saw_read  = saw_read  | burst_read;
                    saw_write = saw_write | burst_write;
                end
                if (burst_write && (burst_wdata !== cur_wline[(rb % 4) * 64 +: 64])) hold_err = 1'b1;
                ml = mem.exists(burst_address) ? mem[burst_address] : '0;
                burst_resp = (pidx < 16) ? resp_pat[pidx] : 1'b1;
                if (burst_resp) begin
                    burst_rdata = ml[(rb % 4) * 64 +: 64];
                    if (burst_write) wr_got[(rb % 4) * 64 +: 64] = burst_wdata;
                    rb++;
                end else begin
                    burst_rdata = 64'hBADD_BADD_BADD_BADD;
                end
                pidx++;
            end else begin
                burst_resp  = 1'b0;
                burst_rdata = 64'hBADD_BADD_BADD_BADD;
                pidx = 0;
                rb   = 0;
            end
        end
    end

    // Runs until every pending request has been answered (or the budget ends).
    // Latency n means the resp was seen n falling edges after requests were set.
    task automatic serve(input int budget, output int i_lat, output int d_lat);
        i_lat = -1;
        d_lat = -1;
        for (int n = 1; n <= budget; n++) begin
            @(negedge clk);
            if (i_pmem_resp) begin
                i_pmem_read = 1'b0;
                if (i_lat < 0) i_lat = n;
                i_at_resp = i_pmem_rdata;
            end
            if (d_pmem_resp) begin
                d_pmem_read  = 1'b0;
                d_pmem_write = 1'b0;
                if (d_lat < 0) d_lat = n;
                d_at_resp = d_pmem_rdata;
            end
            if (!i_pmem_read && !d_pmem_read && !d_pmem_write) break;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int il, dl, d0, i0;
        bit exp_first;

        vecs[0] = mk(1'b0, 1'b1, 1'b0, 32'h0000_1234,
                     {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                      64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111},
                     16'hFFFF, 32'h0000_1220, 1'b0, 5);
        vecs[1] = mk(1'b1, 1'b0, 1'b1, 32'h0000_ABCD,
                     {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                      64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA},
                     16'h0132, 32'h0000_ABC0, 1'b1, 10);
        vecs[2] = mk(1'b1, 1'b1, 1'b0, 32'hFFFF_FFFF,
                     256'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210_0F1E_2D3C_4B5A_6978_8796_A5B4_C3D2_E1F0,
                     16'hFFFF, 32'hFFFF_FFE0, 1'b0, 5);
        vecs[3] = mk(1'b0, 1'b1, 1'b0, 32'h8000_001F,
                     256'hCAFE_0000_0000_0003_CAFE_0000_0000_0002_CAFE_0000_0000_0001_CAFE_0000_0000_0000,
                     16'h5555, 32'h8000_0000, 1'b0, 8);
        vecs[4] = mk(1'b1, 1'b1, 1'b1, 32'h0000_0040,
                     {4{64'h5A5A_A5A5_0F0F_F0F0}},
                     16'hFFFF, 32'h0000_0040, 1'b1, 5);

        mem[32'h0000_0300] = {4{64'h1313_0000_0000_1313}} ^ 256'h3;
        mem[32'h0000_0400] = {4{64'h4040_0000_0000_4040}} ^ 256'h4;
        mem[32'h0000_0200] = {64'h0203_0203_0203_0203, 64'h0202_0202_0202_0202,
                              64'h0201_0201_0201_0201, 64'h0200_0200_0200_0200};

        pass_cnt = 0; chk_cnt = 0;
        i_cnt = 0; d_cnt = 0;
        rw_err = 0; both_resp_err = 0; done_burst_err = 0;
        saw_read = 0; saw_write = 0; hold_err = 0;
        resp_pat = 16'hFFFF; cur_wline = '0; wr_got = '0;
        i_exp = '0; d_exp = '0;
        i_pmem_read = 0; i_pmem_address = '0;
        d_pmem_read = 0; d_pmem_write = 0; d_pmem_address = '0; d_pmem_wdata = '0;

        // ---- reset state ----
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_burst_read",  256'(burst_read),    256'(0));
        chk("rst_burst_write", 256'(burst_write),   256'(0));
        chk("rst_burst_addr",  256'(burst_address), 256'(0));
        chk("rst_i_resp",      256'(i_pmem_resp),   256'(0));
        chk("rst_d_resp",      256'(d_pmem_resp),   256'(0));
        chk("rst_i_rdata",     i_pmem_rdata,        256'(0));
        chk("rst_d_rdata",     d_pmem_rdata,        256'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // ---- simultaneous I and D reads: D first, I right after ----
        order_q.delete();
        resp_pat = 16'hFFFF;
        i_pmem_address = 32'h0000_0310; i_pmem_read = 1'b1;
        d_pmem_address = 32'h0000_0401; d_pmem_read = 1'b1;
        serve(60, il, dl);
        repeat (2) @(negedge clk);
        i_exp = mem[32'h0000_0300];
        d_exp = mem[32'h0000_0400];
        chk("tie_d_latency", 256'(dl), 256'(5));
        chk("tie_i_latency", 256'(il), 256'(11));
        chk("tie_resp_count", 256'(order_q.size()), 256'(2));
        chk("tie_first_is_d", 256'(order_q[0]), 256'(1));
        chk("tie_second_is_i", 256'(order_q[1]), 256'(0));
        chk("tie_i_rdata", i_pmem_rdata, i_exp);
        chk("tie_d_rdata", d_pmem_rdata, d_exp);

        // ---- the same tie three times: D, I, D, I, D, I ----
        order_q.delete();
        for (int r = 0; r < 3; r++) begin
            i_pmem_read = 1'b1;
            d_pmem_read = 1'b1;
            serve(60, il, dl);
        end
        repeat (2) @(negedge clk);
        chk("rep_resp_count", 256'(order_q.size()), 256'(6));
        for (int j = 0; j < 6; j++)
            chk($sformatf("rep_order_%0d", j), 256'(order_q[j]), 256'(j % 2 == 0));

        // ---- D alone, then a tie: history decides only in round-robin ----
        order_q.delete();
        d_pmem_read = 1'b1;
        serve(30, il, dl);
        i_pmem_read = 1'b1;
        d_pmem_read = 1'b1;
        serve(60, il, dl);
        repeat (2) @(negedge clk);
`ifdef PMEM_ARB_ROUND_ROBIN_EN
        exp_first = 1'b0;
`else
        exp_first = 1'b1;
`endif
        chk("hist_resp_count", 256'(order_q.size()), 256'(3));
        chk("hist_tie_winner", 256'(order_q[1]), 256'(exp_first));

        // ---- reset in the middle of a D read, request kept high ----
        d0 = d_cnt;
        d_pmem_address = 32'h0000_0213;
        d_pmem_read = 1'b1;
        repeat (3) @(negedge clk);      // beat 2 is on the bus this cycle
        #1 rst_n = 1'b0;
        #1;
        chk("abort_burst_read", 256'(burst_read), 256'(0));
        chk("abort_d_resp",     256'(d_pmem_resp), 256'(0));
        @(negedge clk);
        chk("abort_d_rdata_cleared", d_pmem_rdata, 256'(0));
        rst_n = 1'b1;
        i_exp = '0;
        d_exp = '0;
        serve(30, il, dl);
        repeat (2) @(negedge clk);
        d_exp = mem[32'h0000_0200];
        chk("restart_latency", 256'(dl), 256'(5));
        chk("restart_line", d_at_resp, d_exp);
        chk("restart_resp_count", 256'(d_cnt - d0), 256'(1));

        // ---- table of single-client transactions ----
        for (int k = 0; k < 5; k++) begin
            vec_t v;
            v = vecs[k];
            if (!v.exp_wr) mem[v.exp_addr] = v.line;
            resp_pat  = v.pat;
            cur_wline = v.line;
            wr_got    = '0;
            saw_read  = 0; saw_write = 0; hold_err = 0;
            i0 = i_cnt; d0 = d_cnt;
            i_pmem_address = v.addr;
            d_pmem_address = v.addr;
            d_pmem_wdata   = v.line;
            i_pmem_read    = !v.is_d;
            d_pmem_read    = v.is_d & v.rd;
            d_pmem_write   = v.is_d & v.wr;
            serve(40, il, dl);
            repeat (2) @(negedge clk);
            chk($sformatf("v%0d_latency", k), 256'(v.is_d ? dl : il), 256'(v.exp_lat));
            chk($sformatf("v%0d_burst_addr", k), 256'(got_addr), 256'(v.exp_addr));
            chk($sformatf("v%0d_saw_write", k), 256'(saw_write), 256'(v.exp_wr));
            chk($sformatf("v%0d_saw_read", k), 256'(saw_read), 256'(!v.exp_wr));
            if (v.exp_wr) begin
                chk($sformatf("v%0d_write_beats", k), wr_got, v.line);
                chk($sformatf("v%0d_wdata_held", k), 256'(hold_err), 256'(0));
            end else begin
                if (v.is_d) d_exp = v.line; else i_exp = v.line;
                chk($sformatf("v%0d_rdata_at_resp", k), v.is_d ? d_at_resp : i_at_resp, v.line);
            end
            chk($sformatf("v%0d_i_rdata", k), i_pmem_rdata, i_exp);
            chk($sformatf("v%0d_d_rdata", k), d_pmem_rdata, d_exp);
            chk($sformatf("v%0d_own_resp_count", k),
                256'(v.is_d ? (d_cnt - d0) : (i_cnt - i0)), 256'(1));
            chk($sformatf("v%0d_other_resp_count", k),
                256'(v.is_d ? (i_cnt - i0) : (d_cnt - d0)), 256'(0));
        end

        // ---- whole-run invariants ----
        chk("never_read_and_write", 256'(rw_err), 256'(0));
        chk("never_two_resps", 256'(both_resp_err), 256'(0));
        chk("burst_low_during_done", 256'(done_burst_err), 256'(0));

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
